axi_read_router: RTL and testbench
==================================

// Module: axi_read_router
// PURPOSE
//  Single-master read-path router placed directly upstream of the AXI default slave.
//  Decodes M_ARADDR against two address windows and forwards each read to one of three ports:
//  port 0, port 1, or port 2 (the default/DECERR slave) when no window matches.
//  Returns that port's R beats to the master. One outstanding read at a time.
//  A saturating miss counter records how many reads were sent to the default slave.
// PARAMETERS
//  W_CID    4              channel ID width
//  W_ID     4              ID width
//  W_ADDR   32             address width
//  W_DATA   32             data width
//  W_SID    W_CID+W_ID     full ID width
//  BASE0    32'h0000_0000  port-0 window base; must be aligned to 2^SZ0
//  SZ0      12             log2 of port-0 window size in bytes
//  BASE1    32'h0000_1000  port-1 window base; must be aligned to 2^SZ1
//  SZ1      12             log2 of port-1 window size in bytes
// PORTS
//  AXI_CLK                             in   1                 clock, rising edge
//  AXI_RST                             in   1                 asynchronous reset, active-high
//  M_ARID/ADDR/LEN/SIZE/BURST          in   W_SID/W_ADDR/8/3/2  master AR payload
//  M_ARVALID                           in   1                 master AR valid
//  M_ARREADY                           out  1                 AR ready to master
//  M_RID/RDATA/RRESP                   out  W_SID/W_DATA/2    R payload to master
//  M_RLAST, M_RVALID                   out  1,1               R last, R valid to master
//  M_RREADY                            in   1                 master R ready
//  S_ARID/ADDR/LEN/SIZE/BURST          out  same as M_AR*     AR payload broadcast to all ports
//  S_ARVALID                           out  3                 per-port AR valid
//  S_ARREADY                           in   3                 per-port AR ready
//  S_RID/RDATA/RRESP                   in   3*W_SID/3*W_DATA/3*2  per-port R payload; port k in slice k
//  S_RLAST, S_RVALID                   in   3,3               per-port R last, R valid
//  S_RREADY                            out  3                 per-port R ready
//  MISS_CNT                            out  16                saturating count of reads routed to port 2
// BEHAVIOUR
//  Decode
//   - hit0 = (ADDR>>SZ0)==(BASE0>>SZ0); hit1 likewise with BASE1/SZ1.
//   - sel = hit0 ? 0 : hit1 ? 1 : 2. Port 0 wins on overlap.
//  FSM (states registered; all channel outputs combinational from state and sel_q)
//   - IDLE: M_ARREADY=0, S_ARVALID=0, M_RVALID=0, S_RREADY=0.
//     If M_ARVALID: sel_q<=sel; if sel==2, MISS_CNT increments (sticks at 16'hFFFF); ->ADDR.
//   - ADDR: S_ARVALID[sel_q]=M_ARVALID; M_ARREADY=S_ARREADY[sel_q]; other S_ARVALID bits 0.
//     On M_ARVALID&S_ARREADY[sel_q] -> DATA.
//   - DATA: M_R* = slice sel_q of S_R*; S_RREADY[sel_q]=M_RREADY; other S_RREADY bits 0.
//     M_ARREADY=0. On M_RVALID&M_RREADY&M_RLAST -> IDLE.
//  Timing and handshakes
//   - S_AR* payload = M_AR* pass-through; the master holds it stable per AXI rules.
//   - AR latency: S_ARVALID rises 1 cycle after M_ARVALID; no AR on the cycle DATA->IDLE.
//   - R path adds 0 cycles; no R buffering.
//  Boundary and error cases
//   - M_ARVALID dropped in ADDR (protocol violation): stay in ADDR; S_ARVALID follows it low.
//   - R beats from unselected ports are ignored; their S_RREADY stays 0.
//   - S_RVALID[sel_q] in ADDR is ignored until DATA is entered.
//   - No RID check; RID is passed through unchanged.
//  Reset (asynchronous, any state, including mid-burst)
//   - State->IDLE, sel_q=2, MISS_CNT=0.
//   - M_ARREADY=0, M_RVALID=0, M_RLAST=0, S_ARVALID=0, S_RREADY=0.
//   - M_RID/RDATA/RRESP show port-2 slice.
// TESTING
//  1. AR addr 0x0000_0010, LEN=0 -> port0 AR, 1 beat returned, RRESP=00, MISS_CNT=0.
//  2. AR addr 0x0000_1FFC, LEN=3 -> port1 AR, 4 beats, M_RLAST on 4th only.
//  3. AR addr 0x8000_0000, LEN=1, ID=0x5A -> port2 (default slave) gives 2 beats
//     RDATA=0xFFFF_FFFF, RRESP=11, RID=0x5A; MISS_CNT=1.
//  4. Back-to-back port0/port2/port1 reads with random M_RREADY stalls ->
//     in-order data, no beat lost or duplicated, unselected S_RREADY always 0.
//  5. Assert AXI_RST during 3rd beat of LEN=7 burst -> all valids 0 same cycle;
//     fresh AR after release routes correctly.
//  6. Force MISS_CNT to 0xFFFE, issue 3 miss reads -> MISS_CNT holds 0xFFFF.

Source files
------------

// File: rtl/axi_read_router.sv
// axi_read_router: single-master AXI read router. Decodes ARADDR against two
// address windows and forwards the read to port 0, port 1 or the default
// slave on port 2. Only one read is outstanding at a time. MISS_CNT counts,
// and saturates at 16'hFFFF, the reads that were routed to port 2.
//
// state | meaning
// IDLE  | waiting for M_ARVALID; latches the decoded port
// ADDR  | AR forwarded to the selected port until it is accepted
// DATA  | R beats of the selected port passed to the master until RLAST
module axi_read_router #(
    parameter int                W_CID  = 4,
    parameter int                W_ID   = 4,
    parameter int                W_ADDR = 32,
    parameter int                W_DATA = 32,
    parameter int                W_SID  = W_CID + W_ID,
    parameter logic [W_ADDR-1:0] BASE0  = 32'h0000_0000,
    parameter int                SZ0    = 12,
    parameter logic [W_ADDR-1:0] BASE1  = 32'h0000_1000,
    parameter int                SZ1    = 12
) (
    input  logic                  AXI_CLK,
    input  logic                  AXI_RST,
    input  logic [W_SID-1:0]      M_ARID,
    input  logic [W_ADDR-1:0]     M_ARADDR,
    input  logic [7:0]            M_ARLEN,
    input  logic [2:0]            M_ARSIZE,
    input  logic [1:0]            M_ARBURST,
    input  logic                  M_ARVALID,
    output logic                  M_ARREADY,
    output logic [W_SID-1:0]      M_RID,
    output logic [W_DATA-1:0]     M_RDATA,
    output logic [1:0]            M_RRESP,
    output logic                  M_RLAST,
    output logic                  M_RVALID,
    input  logic                  M_RREADY,
    output logic [W_SID-1:0]      S_ARID,
    output logic [W_ADDR-1:0]     S_ARADDR,
    output logic [7:0]            S_ARLEN,
    output logic [2:0]            S_ARSIZE,
    output logic [1:0]            S_ARBURST,
    output logic [2:0]            S_ARVALID,
    input  logic [2:0]            S_ARREADY,
    input  logic [3*W_SID-1:0]    S_RID,
    input  logic [3*W_DATA-1:0]   S_RDATA,
    input  logic [5:0]            S_RRESP,
    input  logic [2:0]            S_RLAST,
    input  logic [2:0]            S_RVALID,
    output logic [2:0]            S_RREADY,
    output logic [15:0]           MISS_CNT
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    logic        hit0, hit1;
    logic [1:0]  sel;
    logic [2:0]  sel_oh;
    logic        rvalid_sel, rlast_sel;

    // Window decode; port 0 wins when the windows overlap.
    assign hit0   = (M_ARADDR >> SZ0) == (BASE0 >> SZ0);
    assign hit1   = (M_ARADDR >> SZ1) == (BASE1 >> SZ1);
    assign sel    = hit0 ? 2'd0 : (hit1 ? 2'd1 : 2'd2);
    assign sel_oh = 3'(3'b001 << sel_q);

    // AR payload is a straight pass-through; only the valids are steered.
    assign S_ARID    = M_ARID;
    assign S_ARADDR  = M_ARADDR;
    assign S_ARLEN   = M_ARLEN;
    assign S_ARSIZE  = M_ARSIZE;
    assign S_ARBURST = M_ARBURST;
    assign MISS_CNT  = miss_cnt_q;

    // State, latched port and miss counter registers.
    always_ff @(posedge AXI_CLK or posedge AXI_RST) begin
        if (AXI_RST) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd2;
            miss_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Channel steering: R payload always shows the latched port's slice.
    always_comb begin
        M_RID      = '0;
        M_RDATA    = '0;
        M_RRESP    = '0;
        rvalid_sel = |(S_RVALID & sel_oh);
        rlast_sel  = |(S_RLAST & sel_oh);
        for (int k = 0; k < 3; k++) begin
            if (sel_oh[k]) begin
                M_RID   = S_RID[k*W_SID +: W_SID];
                M_RDATA = S_RDATA[k*W_DATA +: W_DATA];
                M_RRESP = S_RRESP[k*2 +: 2];
            end
        end
        M_ARREADY = 1'b0;
        M_RVALID  = 1'b0;
        M_RLAST   = 1'b0;
        S_ARVALID = 3'b000;
        S_RREADY  = 3'b000;
        case (state_q)
            ST_ADDR: begin
                S_ARVALID = sel_oh & {3{M_ARVALID}};
                M_ARREADY = |(S_ARREADY & sel_oh);
            end
            ST_DATA: begin
                M_RVALID = rvalid_sel;
                M_RLAST  = rlast_sel;
                S_RREADY = sel_oh & {3{M_RREADY}};
            end
            default: ;
        endcase
    end

    // Next-state, port latch and saturating miss count.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (M_ARVALID) begin
                    sel_d   = sel;
                    state_d = ST_ADDR;
                    if (sel == 2'd2 && miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (M_ARVALID && M_ARREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (M_RVALID && M_RREADY && M_RLAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_router.sv
// Randomized bench for axi_read_router: three slave models, a master driver,
// and a reference model that predicts the routed port, beats and miss count.
module tb_axi_read_router;

    logic        AXI_CLK = 1'b0;
    logic        AXI_RST = 1'b1;
    logic [7:0]  M_ARID = '0;
    logic [31:0] M_ARADDR = '0;
    logic [7:0]  M_ARLEN = '0;
    logic [2:0]  M_ARSIZE = 3'd2;
    logic [1:0]  M_ARBURST = 2'b01;
    logic        M_ARVALID = 1'b0;
    logic        M_ARREADY;
    logic [7:0]  M_RID;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST, M_RVALID;
    logic        M_RREADY = 1'b0;
    logic [7:0]  S_ARID;
    logic [31:0] S_ARADDR;
    logic [7:0]  S_ARLEN;
    logic [2:0]  S_ARSIZE;
    logic [1:0]  S_ARBURST;
    logic [2:0]  S_ARVALID;
    logic [2:0]  S_ARREADY = '0;
    logic [23:0] S_RID = '0;
    logic [95:0] S_RDATA = '0;
    logic [5:0]  S_RRESP = '0;
    logic [2:0]  S_RLAST = '0;
    logic [2:0]  S_RVALID = '0;
    logic [2:0]  S_RREADY;
    logic [15:0] MISS_CNT;

    axi_read_router dut (
        .AXI_CLK(AXI_CLK), .AXI_RST(AXI_RST),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
        .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID),
        .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
        .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
        .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .MISS_CNT(MISS_CNT)
    );

    always #5 AXI_CLK = ~AXI_CLK;

    typedef struct {
        int         port;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
    } ar_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    ar_t   exp_ar_q[$];
    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    popped = 0;
    int    cur_port = -1;
    int    miss_model = 0;

    logic        busy  [3];
    logic        taken [3];
    int          s_beat[3];
    logic [7:0]  s_len [3];
    logic [7:0]  s_id  [3];
    logic [31:0] s_addr[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address map as plain ranges: [0,4K) port 0, [4K,8K) port 1, rest port 2.
    function automatic int ref_port(input logic [31:0] a);
        if (a < 32'h0000_1000) return 0;
        if (a < 32'h0000_2000) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] beat_data(input int p, input logic [31:0] a, input int b);
        if (p == 2) return 32'hFFFF_FFFF;
        return {4'(p + 1), 4'(b), a[23:0]};
    endfunction

    // Slave models: drive at negedge, observe handshakes 1 ns later.
    initial begin
        for (int k = 0; k < 3; k++) begin
            busy[k] = 1'b0; taken[k] = 1'b0; s_beat[k] = 0;
            s_len[k] = '0; s_id[k] = '0; s_addr[k] = '0;
        end
        forever begin
            @(negedge AXI_CLK);
            for (int k = 0; k < 3; k++) begin
                if (busy[k]) begin
                    S_ARREADY[k] = 1'b0;
                    if (!(S_RVALID[k] && !taken[k]))
                        S_RVALID[k] = ($urandom_range(0, 3) != 0);
                    S_RDATA[k*32 +: 32] = beat_data(k, s_addr[k], s_beat[k]);
                    S_RID[k*8 +: 8]     = s_id[k];
                    S_RRESP[k*2 +: 2]   = (k == 2) ? 2'b11 : 2'b00;
                    S_RLAST[k]          = (s_beat[k] == int'(s_len[k]));
                end else begin
                    S_ARREADY[k]        = ($urandom_range(0, 1) != 0);
                    S_RVALID[k]         = ($urandom_range(0, 1) != 0);
                    S_RDATA[k*32 +: 32] = $urandom;
                    S_RID[k*8 +: 8]     = 8'($urandom);
                    S_RRESP[k*2 +: 2]   = 2'($urandom);
                    S_RLAST[k]          = 1'($urandom);
                end
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                taken[k] = 1'b0;
                if (AXI_RST) begin
                    busy[k] = 1'b0;
                end else if (busy[k]) begin
                    if (S_RVALID[k] && S_RREADY[k]) begin
                        taken[k] = 1'b1;
                        s_beat[k]++;
                        if (s_beat[k] > int'(s_len[k])) busy[k] = 1'b0;
                    end
                end else if (S_ARVALID[k] && S_ARREADY[k]) begin
                    if (exp_ar_q.size() == 0) begin
                        chk("ar_unexpected", 64'(k), 64'hFF);
                    end else begin
                        ar_t e;
                        e = exp_ar_q.pop_front();
                        chk("ar_route", 64'(k), 64'(e.port));
                        chk("ar_payload", {16'h0, S_ARADDR, S_ARLEN, S_ARID}, {16'h0, e.addr, e.len, e.id});
                    end
                    busy[k]   = 1'b1;
                    s_addr[k] = S_ARADDR;
                    s_len[k]  = S_ARLEN;
                    s_id[k]   = S_ARID;
                    s_beat[k] = 0;
                end
            end
        end
    end

    // Master R-ready with random stalls.
    initial forever begin
        @(negedge AXI_CLK);
        M_RREADY = ($urandom_range(0, 3) != 0);
    end

    // R monitor: pops the scoreboard whenever a beat is transferred.
    initial forever begin
        logic [2:0] m;
        @(negedge AXI_CLK);
        #2;
        if (!AXI_RST) begin
            m = (cur_port >= 0) ? 3'(1 << cur_port) : 3'b000;
            if (S_RREADY != 3'b000)
                chk("unsel_rready", 64'(S_RREADY & ~m), 64'h0);
            if (M_RVALID && M_RREADY) begin
                if (exp_q.size() == 0) begin
                    chk("r_extra_beat", {M_RID, M_RDATA}, 64'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("r_beat", {21'h0, M_RID, M_RDATA, M_RRESP, M_RLAST},
                                  {21'h0, e.id, e.data, e.resp, e.last});
                    popped++;
                end
            end
        end
    end

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] len, input logic [7:0] id);
        int p;
        int n;
        ar_t e;
        beat_t b;
        p = ref_port(a);
        @(negedge AXI_CLK);
        e.port = p; e.addr = a; e.len = len; e.id = id;
        exp_ar_q.push_back(e);
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.data = beat_data(p, a, i);
            b.resp = (p == 2) ? 2'b11 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
        if (p == 2 && miss_model < 65535) miss_model++;
        cur_port  = p;
        M_ARADDR  = a;
        M_ARLEN   = len;
        M_ARID    = id;
        M_ARVALID = 1'b1;
        n = 0;
        #1;
        while (!M_ARREADY && n < 200) begin
            @(negedge AXI_CLK);
            #1;
            n++;
        end
        if (n >= 200) chk("ar_timeout", 64'(n), 64'h0);
        @(negedge AXI_CLK);
        M_ARVALID = 1'b0;
        M_ARADDR  = $urandom;
        M_ARID    = 8'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge AXI_CLK);
            n++;
        end
        chk("r_done", 64'(exp_q.size()), 64'h0);
        @(negedge AXI_CLK);
        #3;
        chk("miss_cnt", 64'(MISS_CNT), 64'(miss_model));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [7:0] id);
        issue_ar(a, len, id);
        wait_done();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return $urandom_range(0, 32'h0000_0FFF);
            1:       return 32'h0000_1000 + $urandom_range(0, 32'h0000_0FFF);
            default: return 32'h0000_2000 + $urandom_range(0, 32'hFFFF_0000);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        repeat (3) @(negedge AXI_CLK);
        #3;
        chk("reset_outs", {58'h0, M_ARREADY, M_RVALID, M_RLAST, |S_ARVALID, |S_RREADY, 1'b0},
                          64'h0);
        chk("reset_miss", 64'(MISS_CNT), 64'h0);
        chk("reset_rslice", {M_RID, M_RDATA, M_RRESP}, {S_RID[23:16], S_RDATA[95:64], S_RRESP[5:4]});
        @(negedge AXI_CLK);
        AXI_RST = 1'b0;

        do_read(32'h0000_0010, 8'd0, 8'h11);
        do_read(32'h0000_1FFC, 8'd3, 8'h22);
        do_read(32'h8000_0000, 8'd1, 8'h5A);

        for (int i = 0; i < 30; i++) begin
            case (i % 3)
                0:       do_read($urandom_range(0, 32'h0FFF), 8'($urandom_range(0, 7)), 8'($urandom));
                1:       do_read(32'h0000_2000 + $urandom_range(0, 32'hFFFF_0000), 8'($urandom_range(0, 7)), 8'($urandom));
                default: do_read(rand_addr(), 8'($urandom_range(0, 7)), 8'($urandom));
            endcase
        end

        // Reset in the middle of an 8-beat burst.
        target = popped + 2;
        issue_ar(32'h0000_0200, 8'd7, 8'h3C);
        begin
            int n;
            n = 0;
            while (popped < target && n < 500) begin
                @(negedge AXI_CLK);
                n++;
            end
            if (n >= 500) chk("burst_timeout", 64'(n), 64'h0);
        end
        AXI_RST = 1'b1;
        #1;
        chk("midburst_rst_outs", {58'h0, M_ARREADY, M_RVALID, M_RLAST, |S_ARVALID, |S_RREADY, 1'b0},
                                 64'h0);
        chk("midburst_rst_miss", 64'(MISS_CNT), 64'h0);
        exp_q.delete();
        exp_ar_q.delete();
        miss_model = 0;
        cur_port = -1;
        repeat (2) @(negedge AXI_CLK);
        AXI_RST = 1'b0;
        do_read(32'h0000_1234, 8'd2, 8'h77);
        do_read(32'h0000_0FF0, 8'd1, 8'h78);

        // Miss counter saturation from a preloaded value.
        @(negedge AXI_CLK);
        #1;
        force dut.miss_cnt_q = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        miss_model = 65534;
        #1;
        chk("miss_preload", 64'(MISS_CNT), 64'hFFFE);
        for (int i = 0; i < 3; i++)
            do_read(32'h4000_0000 + 32'(i * 16), 8'($urandom_range(0, 2)), 8'(i));
        chk("miss_sat", 64'(MISS_CNT), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
